// File: rtl/mcpu_core_pkg.sv
// Shared widths, the skid-buffer entry layout and the writeback exception FSM
// encoding for the execute->writeback stage.
package mcpu_core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int PC_W   = 28;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd_num;
    logic              rd_we;
    logic [PC_W-1:0]   pc;
    logic              alu_invalid;
  } skid_entry_t;

  localparam int ENTRY_W = $bits(skid_entry_t);

  typedef enum logic {
    RUN = 1'b0,
    EXC = 1'b1
  } wb_state_t;

  // An entry produces a register-file write only if it targets a real GPR
  // and the ALU did not flag it as illegal.
  function automatic logic rf_write_qual(skid_entry_t e);
    return e.rd_we && (e.rd_num != '0) && !e.alu_invalid;
  endfunction

endpackage

// File: rtl/mcpu_skid2.sv
// Generic 2-entry skid buffer. in_ready is a register, so downstream
// backpressure never forms a combinational path to the producer.
module mcpu_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         hold,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; the producer holds valid and data stable until it does.
  logic [W-1:0] e0_q, e1_q, e0_d, e1_d;
  logic         v0_q, v1_q, v0_d, v1_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  assign push      = in_valid && ready_q;
  assign pop       = v0_q && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = v0_q;
  assign out_data  = e0_q;

  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (clear) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (v1_q) begin
            e0_d = e1_q;
            e1_d = in_data;
          end else begin
            e0_d = in_data;
          end
        end
        2'b01: begin
          e0_d = e1_q;
          v0_d = v1_q;
          v1_d = 1'b0;
        end
        2'b10: begin
          if (!v0_q) begin
            e0_d = in_data;
            v0_d = 1'b1;
          end else begin
            e1_d = in_data;
            v1_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Ready next cycle only if a slot will be free and the owner allows it.
    ready_d = !hold && !(v0_d && v1_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/mcpu_core_pc2wb.sv
// Execute->writeback stage: skid-buffers ALU results, drives the register-file
// write port and bypass, and turns ALU-illegal results into a precise exception.
module mcpu_core_pc2wb
  import mcpu_core_pkg::*;
#(
  parameter int DATA_W = mcpu_core_pkg::DATA_W,
  parameter int REG_W  = mcpu_core_pkg::REG_W,
  parameter int PC_W   = mcpu_core_pkg::PC_W
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst_n,
  input  logic              pc2wb_in_valid,
  output logic              pc2wb_in_ready,
  input  logic [DATA_W-1:0] pc2wb_in_result,
  input  logic              pc2wb_in_alu_invalid,
  input  logic [REG_W-1:0]  pc2wb_in_rd_num,
  input  logic              pc2wb_in_rd_we,
  input  logic [PC_W-1:0]   pc2wb_in_pc,
  input  logic              wb_flush,
  output logic              wb2rf_valid,
  input  logic              wb2rf_ready,
  output logic [REG_W-1:0]  wb2rf_rd_num,
  output logic [DATA_W-1:0] wb2rf_rd_data,
  output logic              wb2byp_valid,
  output logic [REG_W-1:0]  wb2byp_rd_num,
  output logic [DATA_W-1:0] wb2byp_rd_data,
  output logic              wb_exc_valid,
  output logic [PC_W-1:0]   wb_exc_pc,
  input  logic              wb_exc_ack,
  output logic              wb_dbg_state
);

  skid_entry_t in_entry, head;
  logic        head_valid, head_pop, wr_qual, fault;
  logic        skid_clear, skid_hold;

  wb_state_t   state_q, state_d;
  logic        exc_valid_q, exc_valid_d;
  logic [PC_W-1:0] exc_pc_q, exc_pc_d;

  always_comb begin
    in_entry             = '0;
    in_entry.result      = pc2wb_in_result;
    in_entry.rd_num      = pc2wb_in_rd_num;
    in_entry.rd_we       = pc2wb_in_rd_we;
    in_entry.pc          = pc2wb_in_pc;
    in_entry.alu_invalid = pc2wb_in_alu_invalid;
  end

  assign wr_qual = head_valid && rf_write_qual(head);
  // Faulting heads are never popped; the fault path clears the buffer instead.
  assign head_pop   = !head.alu_invalid && (!wr_qual || wb2rf_ready);
  assign fault      = (state_q == RUN) && head_valid && head.alu_invalid && !wb_flush;
  assign skid_clear = wb_flush || fault;
  assign skid_hold  = (state_d == EXC);

  mcpu_skid2 #(.W(ENTRY_W)) u_skid (
    .clk       (clkrst_core_clk),
    .rst_n     (clkrst_core_rst_n),
    .clear     (skid_clear),
    .hold      (skid_hold),
    .in_valid  (pc2wb_in_valid),
    .in_ready  (pc2wb_in_ready),
    .in_data   (in_entry),
    .out_valid (head_valid),
    .out_ready (head_pop),
    .out_data  (head)
  );

  always_comb begin
    state_d     = state_q;
    exc_valid_d = exc_valid_q;
    exc_pc_d    = exc_pc_q;
    case (state_q)
      RUN: begin
        if (fault) begin
          state_d     = EXC;
          exc_valid_d = 1'b1;
          exc_pc_d    = head.pc;
        end
      end
      EXC: begin
        if (wb_exc_ack) begin
          state_d     = RUN;
          exc_valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      state_q     <= RUN;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  // Write and bypass share one qualification so they can never disagree.
  assign wb2rf_valid    = wr_qual;
  assign wb2rf_rd_num   = wr_qual ? head.rd_num : '0;
  assign wb2rf_rd_data  = wr_qual ? head.result : '0;
  assign wb2byp_valid   = wr_qual;
  assign wb2byp_rd_num  = wr_qual ? head.rd_num : '0;
  assign wb2byp_rd_data = wr_qual ? head.result : '0;
  assign wb_exc_valid   = exc_valid_q;
  assign wb_exc_pc      = exc_pc_q;
  assign wb_dbg_state   = (state_q == EXC);

endmodule

// File: tb/tb_mcpu_core_pc2wb.sv
// Directed self-checking bench for mcpu_core_pc2wb.
module tb_mcpu_core_pc2wb;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int PW = 28;
  localparam int LW = RW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_result = '0;
  logic          in_alu_invalid = 1'b0;
  logic [RW-1:0] in_rd_num = '0;
  logic          in_rd_we = 1'b0;
  logic [PW-1:0] in_pc = '0;
  logic          flush = 1'b0;
  logic          rf_valid;
  logic          rf_ready = 1'b0;
  logic [RW-1:0] rf_rd_num;
  logic [DW-1:0] rf_rd_data;
  logic          byp_valid;
  logic [RW-1:0] byp_rd_num;
  logic [DW-1:0] byp_rd_data;
  logic          exc_valid;
  logic [PW-1:0] exc_pc;
  logic          exc_ack = 1'b0;
  logic          dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [LW-1:0] wr_log[$];
  logic [LW-1:0] exp_q[$];

  mcpu_core_pc2wb dut (
    .clkrst_core_clk      (clk),
    .clkrst_core_rst_n    (rst_n),
    .pc2wb_in_valid       (in_valid),
    .pc2wb_in_ready       (in_ready),
    .pc2wb_in_result      (in_result),
    .pc2wb_in_alu_invalid (in_alu_invalid),
    .pc2wb_in_rd_num      (in_rd_num),
    .pc2wb_in_rd_we       (in_rd_we),
    .pc2wb_in_pc          (in_pc),
    .wb_flush             (flush),
    .wb2rf_valid          (rf_valid),
    .wb2rf_ready          (rf_ready),
    .wb2rf_rd_num         (rf_rd_num),
    .wb2rf_rd_data        (rf_rd_data),
    .wb2byp_valid         (byp_valid),
    .wb2byp_rd_num        (byp_rd_num),
    .wb2byp_rd_data       (byp_rd_data),
    .wb_exc_valid         (exc_valid),
    .wb_exc_pc            (exc_pc),
    .wb_exc_ack           (exc_ack),
    .wb_dbg_state         (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so negedge sees exactly what the next edge sees.
  always @(negedge clk) begin
    if (rst_n && rf_valid && rf_ready) wr_log.push_back({rf_rd_num, rf_rd_data});
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [RW-1:0] rd, input logic we,
                          input logic [DW-1:0] res, input logic [PW-1:0] pc, input logic inv);
    in_valid       = v;
    in_rd_num      = rd;
    in_rd_we       = we;
    in_result      = res;
    in_pc          = pc;
    in_alu_invalid = inv;
  endtask

  task automatic idle();
    drive_in(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Scoreboard: compare logged writes with the expected queue.
  task automatic check_log(input string name);
    tests_run++;
    if (wr_log.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_log.size()) begin
        tests_run++;
        if (wr_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL %s_write%0d: got %h, expected %h", name, i, wr_log[i], exp_q[i]);
        end
      end
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, expected 1", in_ready); end
    tests_run++; if (rf_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_valid: got %b, expected 0", rf_valid); end
    tests_run++; if (byp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_byp_valid: got %b, expected 0", byp_valid); end
    tests_run++; if (exc_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_exc_valid: got %b, expected 0", exc_valid); end
    tests_run++; if (exc_pc !== '0) begin tests_failed++; $display("FAIL reset_exc_pc: got %h, expected 0", exc_pc); end
    tests_run++; if ({rf_rd_num, rf_rd_data, byp_rd_num, byp_rd_data} !== '0) begin tests_failed++; $display("FAIL reset_data: got %h/%h, expected 0", rf_rd_num, rf_rd_data); end
    tests_run++; if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL reset_state: got %b, expected 0", dbg_state); end
    rst_n = 1'b1;
    wr_log.delete();
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] rds[3];
    logic [DW-1:0] res[3];
    rds = '{5'd1, 5'd2, 5'd3};
    res = '{32'h11, 32'h22, 32'h33};
    rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, rds[i], 1'b1, res[i], 28'h10 + 28'(i * 4), 1'b0);
      step();
      tests_run++; if (rf_valid !== 1'b1 || rf_rd_num !== rds[i] || rf_rd_data !== res[i]) begin tests_failed++; $display("FAIL b2b_write%0d: got v=%b rd=%0d d=%h, expected v=1 rd=%0d d=%h", i, rf_valid, rf_rd_num, rf_rd_data, rds[i], res[i]); end
      tests_run++; if (byp_valid !== 1'b1 || byp_rd_num !== rds[i] || byp_rd_data !== res[i]) begin tests_failed++; $display("FAIL b2b_byp%0d: got v=%b rd=%0d d=%h, expected v=1 rd=%0d d=%h", i, byp_valid, byp_rd_num, byp_rd_data, rds[i], res[i]); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready%0d: got %b, expected 1", i, in_ready); end
    end
    idle();
    step();
    tests_run++; if (rf_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drained: got %b, expected 0", rf_valid); end
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h22});
    exp_q.push_back({5'd3, 32'h33});
    check_log("b2b");
  endtask

  task automatic test_backpressure();
    rf_ready = 1'b0;
    drive_in(1'b1, 5'd4, 1'b1, 32'hA, 28'h20, 1'b0);
    step();
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after1: got %b, expected 1", in_ready); end
    drive_in(1'b1, 5'd5, 1'b1, 32'hB, 28'h24, 1'b0);
    step();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_after2: got %b, expected 0", in_ready); end
    drive_in(1'b1, 5'd6, 1'b1, 32'hC, 28'h28, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tests_run++; if (rf_valid !== 1'b1 || rf_rd_num !== 5'd4 || rf_rd_data !== 32'hA) begin tests_failed++; $display("FAIL bp_hold%0d: got v=%b rd=%0d d=%h, expected v=1 rd=4 d=a", c, rf_valid, rf_rd_num, rf_rd_data); end
      step();
    end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_stall: got %b, expected 0", in_ready); end
    rf_ready = 1'b1;
    step();
    tests_run++; if (rf_rd_num !== 5'd5 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_second: got rd=%0d ready=%b, expected rd=5 ready=1", rf_rd_num, in_ready); end
    step();
    tests_run++; if (rf_valid !== 1'b1 || rf_rd_num !== 5'd6 || rf_rd_data !== 32'hC) begin tests_failed++; $display("FAIL bp_third: got v=%b rd=%0d d=%h, expected v=1 rd=6 d=c", rf_valid, rf_rd_num, rf_rd_data); end
    idle();
    step();
    tests_run++; if (rf_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %b, expected 0", rf_valid); end
    exp_q.push_back({5'd4, 32'hA});
    exp_q.push_back({5'd5, 32'hB});
    exp_q.push_back({5'd6, 32'hC});
    check_log("bp");
  endtask

  task automatic test_r0_nowrite();
    // Register file stalled: non-writing heads must still retire on their own.
    rf_ready = 1'b0;
    drive_in(1'b1, 5'd0, 1'b1, 32'hDEAD, 28'h30, 1'b0);
    step();
    tests_run++; if (rf_valid !== 1'b0 || byp_valid !== 1'b0) begin tests_failed++; $display("FAIL r0_suppress: got rf=%b byp=%b, expected 0/0", rf_valid, byp_valid); end
    drive_in(1'b1, 5'd7, 1'b0, 32'h77, 28'h34, 1'b0);
    step();
    tests_run++; if (rf_valid !== 1'b0 || byp_valid !== 1'b0) begin tests_failed++; $display("FAIL nowe_suppress: got rf=%b byp=%b, expected 0/0", rf_valid, byp_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL r0_retired: ready got %b, expected 1", in_ready); end
    drive_in(1'b1, 5'd10, 1'b1, 32'h1010, 28'h38, 1'b0);
    step();
    tests_run++; if (rf_valid !== 1'b1 || rf_rd_num !== 5'd10 || rf_rd_data !== 32'h1010) begin tests_failed++; $display("FAIL nowe_retired: got v=%b rd=%0d d=%h, expected v=1 rd=10 d=1010", rf_valid, rf_rd_num, rf_rd_data); end
    rf_ready = 1'b1;
    idle();
    step();
    tests_run++; if (rf_valid !== 1'b0) begin tests_failed++; $display("FAIL r0_drained: got %b, expected 0", rf_valid); end
    exp_q.push_back({5'd10, 32'h1010});
    check_log("r0");
  endtask

  task automatic test_illegal();
    rf_ready = 1'b1;
    drive_in(1'b1, 5'd3, 1'b1, 32'h5, 28'h100, 1'b1);
    step();
    tests_run++; if (rf_valid !== 1'b0 || exc_valid !== 1'b0) begin tests_failed++; $display("FAIL ill_head: got rf=%b exc=%b, expected 0/0", rf_valid, exc_valid); end
    drive_in(1'b1, 5'd8, 1'b1, 32'h88, 28'h104, 1'b0);
    step();
    idle();
    tests_run++; if (exc_valid !== 1'b1 || exc_pc !== 28'h100) begin tests_failed++; $display("FAIL ill_exc: got v=%b pc=%h, expected v=1 pc=100", exc_valid, exc_pc); end
    tests_run++; if (in_ready !== 1'b0 || dbg_state !== 1'b1) begin tests_failed++; $display("FAIL ill_stall: got ready=%b state=%b, expected 0/1", in_ready, dbg_state); end
    flush = 1'b1;
    step();
    tests_run++; if (exc_valid !== 1'b1 || in_ready !== 1'b0 || rf_valid !== 1'b0) begin tests_failed++; $display("FAIL ill_flush_keeps: got exc=%b ready=%b rf=%b, expected 1/0/0", exc_valid, in_ready, rf_valid); end
    exc_ack = 1'b1;
    step();
    flush = 1'b0;
    exc_ack = 1'b0;
    tests_run++; if (exc_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 1'b0) begin tests_failed++; $display("FAIL ill_ack: got exc=%b ready=%b state=%b, expected 0/1/0", exc_valid, in_ready, dbg_state); end
    step();
    tests_run++; if (rf_valid !== 1'b0) begin tests_failed++; $display("FAIL ill_younger: got %b, expected 0", rf_valid); end
    check_log("ill");
  endtask

  task automatic test_flush();
    rf_ready = 1'b0;
    drive_in(1'b1, 5'd11, 1'b1, 32'hB1, 28'h40, 1'b0);
    step();
    drive_in(1'b1, 5'd12, 1'b1, 32'hB2, 28'h44, 1'b0);
    step();
    drive_in(1'b1, 5'd13, 1'b1, 32'hB3, 28'h48, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    tests_run++; if (rf_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_full: got rf=%b ready=%b, expected 0/1", rf_valid, in_ready); end
    // Flush while ready is high, so the concurrent accept is a real handshake.
    drive_in(1'b1, 5'd14, 1'b1, 32'hB4, 28'h4C, 1'b0);
    step();
    drive_in(1'b1, 5'd15, 1'b1, 32'hB5, 28'h50, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    rf_ready = 1'b1;
    tests_run++; if (rf_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_accept: got rf=%b ready=%b, expected 0/1", rf_valid, in_ready); end
    step();
    step();
    check_log("flush");
  endtask

  task automatic test_reset_mid();
    rf_ready = 1'b0;
    drive_in(1'b1, 5'd1, 1'b1, 32'h1, 28'h200, 1'b1);
    step();
    idle();
    step();
    tests_run++; if (exc_valid !== 1'b1 || exc_pc !== 28'h200) begin tests_failed++; $display("FAIL rst_pre_exc: got v=%b pc=%h, expected v=1 pc=200", exc_valid, exc_pc); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++; if (exc_valid !== 1'b0 || exc_pc !== '0 || in_ready !== 1'b1 || dbg_state !== 1'b0) begin tests_failed++; $display("FAIL rst_exc_cleared: got v=%b pc=%h ready=%b state=%b, expected 0/0/1/0", exc_valid, exc_pc, in_ready, dbg_state); end
    drive_in(1'b1, 5'd1, 1'b1, 32'h1, 28'h210, 1'b0);
    step();
    drive_in(1'b1, 5'd2, 1'b1, 32'h2, 28'h214, 1'b0);
    step();
    idle();
    tests_run++; if (in_ready !== 1'b0 || rf_rd_num !== 5'd1) begin tests_failed++; $display("FAIL rst_pre_full: got ready=%b rd=%0d, expected 0/1", in_ready, rf_rd_num); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++; if (rf_valid !== 1'b0 || byp_valid !== 1'b0 || in_ready !== 1'b1 || rf_rd_data !== '0) begin tests_failed++; $display("FAIL rst_entries_dropped: got rf=%b byp=%b ready=%b d=%h, expected 0/0/1/0", rf_valid, byp_valid, in_ready, rf_rd_data); end
    rf_ready = 1'b1;
    drive_in(1'b1, 5'd9, 1'b1, 32'h99, 28'h220, 1'b0);
    step();
    idle();
    tests_run++; if (rf_valid !== 1'b1 || rf_rd_num !== 5'd9 || rf_rd_data !== 32'h99) begin tests_failed++; $display("FAIL rst_after_write: got v=%b rd=%0d d=%h, expected v=1 rd=9 d=99", rf_valid, rf_rd_num, rf_rd_data); end
    step();
    tests_run++; if (rf_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_after_drained: got %b, expected 0", rf_valid); end
    exp_q.push_back({5'd9, 32'h99});
    check_log("rst");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_r0_nowrite();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mcpu_core_pc2wb.md
Name: mcpu_core_pc2wb

Overview:
- Execute→writeback pipeline stage directly downstream of the core ALU.
- Captures the ALU result, destination register and `pc_alu_invalid` flag each cycle, then drives the register-file write port and the bypass network.
- Uses a 2-entry skid buffer so a register-file stall does not create a combinational ready path back into execute.
- Converts `pc_alu_invalid` into a precise illegal-instruction exception with an ack handshake.

Parameters:
- DATA_W, 32, width of result and register data
- REG_W, 5, register-number width (32 GPRs; r0 hard-zero)
- PC_W, 28, width of the instruction-packet PC carried for exception reporting

Ports:
- clkrst_core_clk  in  1  core clock; all state on rising edge
- clkrst_core_rst_n  in  1  reset, synchronous, active-low
- pc2wb_in_valid  in  1  execute holds a valid instruction
- pc2wb_in_ready  out  1  stage can accept this cycle (registered)
- pc2wb_in_result  in  DATA_W  ALU result
- pc2wb_in_alu_invalid  in  1  ALU reported illegal opcode/compare type
- pc2wb_in_rd_num  in  REG_W  destination register
- pc2wb_in_rd_we  in  1  instruction writes rd (already predicate-qualified)
- pc2wb_in_pc  in  PC_W  packet PC
- wb_flush  in  1  discard all buffered entries
- wb2rf_valid  out  1  write request to register file
- wb2rf_ready  in  1  register file accepts write
- wb2rf_rd_num  out  REG_W  write address
- wb2rf_rd_data  out  DATA_W  write data
- wb2byp_valid  out  1  bypass entry valid (head entry, rd_we=1, rd≠0)
- wb2byp_rd_num  out  REG_W  bypass register number
- wb2byp_rd_data  out  DATA_W  bypass data
- wb_exc_valid  out  1  illegal-instruction exception pending
- wb_exc_pc  out  PC_W  PC of faulting packet
- wb_exc_ack  in  1  exception consumed by control

Behaviour:
- Reset (`rst_n=0` at edge): both skid entries invalid; FSM=RUN; `pc2wb_in_ready=1`; `wb2rf_valid=0`; `wb2byp_valid=0`; `wb_exc_valid=0`; `wb_exc_pc=0`. Data outputs are 0. Reset mid-operation drops every entry and any pending exception.
- Accept: entry captured when `pc2wb_in_valid & pc2wb_in_ready`.
  - Entry fields: result, rd_num, rd_we, pc, alu_invalid.
  - Latency from accept to `wb2rf_valid` is 1 cycle.
- Skid buffer: 2 entries, head/tail order preserved.
  - `pc2wb_in_ready` is registered: 1 iff next-cycle occupancy ≤1 and FSM=RUN.
  - An accept while 1 entry is held and the head is not drained fills entry 2.
  - Simultaneous accept and drain keeps occupancy unchanged.
- Drain of a normal head entry:
  - `wb2rf_valid = head_valid & rd_we & (rd_num≠0) & ~alu_invalid`.
  - Head retires on `wb2rf_valid & wb2rf_ready`.
  - Head with `rd_we=0` or `rd=0` retires in 1 cycle with no write.
- `wb2rf_*` outputs hold stable while `valid & ~ready`.
- Bypass outputs are combinational from the head entry; they mirror `wb2rf` validity.
- Exception FSM:
  - RUN: head with `alu_invalid=1` → set `wb_exc_valid=1` and `wb_exc_pc=head.pc`; suppress the write; discard both entries; go EXC.
  - EXC: `pc2wb_in_ready=0`; hold `wb_exc_*`. On `wb_exc_ack` → clear `wb_exc_valid`, go RUN, and `pc2wb_in_ready=1` next cycle.
  - Younger entries behind a faulting head are never written.
- Flush: `wb_flush` invalidates both entries at the edge.
  - An accept in the same cycle as flush is also dropped.
  - Flush does not clear a pending exception.
  - `wb_flush` and `wb_exc_ack` in the same cycle: both take effect.
- Priority per edge: reset > flush > exception detect > drain/accept.
- Widths: no arithmetic; data passes through unmodified. r0 writes are always suppressed.

Decomposition:
- Package `mcpu_core_pkg`: DATA_W/REG_W/PC_W constants, the skid-entry struct (result, rd_num, rd_we, pc, alu_invalid), and the FSM enum {RUN, EXC}.
- One sub-module, `mcpu_skid2`: generic 2-entry valid/ready skid buffer parameterised on entry width. The stage top holds the exception FSM, r0/write qualification and bypass muxing.

Test Plan:
- Back-to-back writes: 3 instructions (rd=1,2,3; results 0x11,0x22,0x33), `wb2rf_ready=1` → one write per cycle, each 1 cycle after accept, order 1,2,3; `pc2wb_in_ready` stays 1.
- Backpressure: `wb2rf_ready=0` for 4 cycles while issuing rd=4 (0xA), rd=5 (0xB), rd=6 (0xC).
  - Entries 1–2 are accepted; `pc2wb_in_ready` falls after the 2nd; `wb2rf_*` stays rd=4/0xA.
  - On release, writes come out 4, 5, 6 with no loss or duplication.
- r0/no-write: rd=0 result 0xDEAD with rd_we=1, then rd=7 with rd_we=0 → no `wb2rf_valid`, no bypass, both retire in 1 cycle each.
- Illegal op: accept pc=0x100 alu_invalid=1, followed by pc=0x104 rd=8.
  - `wb_exc_valid=1` with `wb_exc_pc=0x100`; rd=8 is never written; `pc2wb_in_ready=0` until ack.
  - Ack → `wb_exc_valid=0`, ready=1 next cycle.
- Flush with concurrent accept: 2 entries buffered, `wb2rf_ready=0`, `wb_flush=1` with `pc2wb_in_valid=1` → no writes ever issued from those 3 instructions; ready=1 the next cycle.
- Reset mid-stall: 2 entries buffered and an exception pending, then `rst_n=0` for 1 cycle → all outputs at reset values; a new rd=9 (0x99) instruction writes normally afterwards.
